// File: rtl/axis_fifo_wr_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : axis_arb_pkg
// Purpose : Shared types and helpers for the AXI-stream FIFO write arbiter.
//           - arb_state_e : arbiter FSM states
//           - grant_w()   : width of a source index for a given source count
//           - rr_pick()   : round-robin selection starting after the last grant
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package axis_arb_pkg;

  // Upper bound on the number of sources; rr_pick works on vectors of this size.
  localparam int MaxSrc    = 8;
  localparam int MaxGrantW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a source index; never less than one bit.
  function automatic int grant_w(input int num_src);
    return (num_src < 2) ? 1 : $clog2(num_src);
  endfunction

  // Returns the first index with valid set, searching last_grant+1,
  // last_grant+2, ... modulo num_src. If nothing is valid, last_grant is
  // returned unchanged (callers only use the result when something is valid).
  function automatic int rr_pick(
    input logic [MaxSrc-1:0] valid,
    input int                last_grant,
    input int                num_src
  );
    int   pick;
    int   idx;
    logic found;
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= MaxSrc; i++) begin
      idx = (last_grant + i) % num_src;
      if (!found && (i <= num_src) && valid[idx[MaxGrantW-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_fifo_wr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : axis_fifo_wr_arbiter_if
// Purpose : Stream bundle between the NumSrc sources, the arbiter and the
//           FIFO write port.
// Ports   : srcData/srcValid/srcLast  per-source stream into the arbiter
//           srcReady                  per-source ready from the arbiter
//           writeData/Valid/Last      merged stream towards the FIFO
//           writeDataReady            FIFO back-pressure
// Modports: master - arbiter side; slave - sources + FIFO side
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface axis_fifo_wr_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int NumSrc    = 2
);

  logic [NumSrc-1:0][DataWidth-1:0] srcData;
  logic [NumSrc-1:0]                srcValid;
  logic [NumSrc-1:0]                srcLast;
  logic [NumSrc-1:0]                srcReady;

  logic [DataWidth-1:0]             writeData;
  logic                             writeDataValid;
  logic                             writeDataLast;
  logic                             writeDataReady;

  modport master (
    input  srcData, srcValid, srcLast, writeDataReady,
    output srcReady, writeData, writeDataValid, writeDataLast
  );

  modport slave (
    output srcData, srcValid, srcLast, writeDataReady,
    input  srcReady, writeData, writeDataValid, writeDataLast
  );

endinterface

`default_nettype wire

// File: rtl/axis_fifo_wr_arbiter_skid_buf.sv
//------------------------------------------------------------------------------
// Module  : axis_skid_buf
// Purpose : Two-entry skid buffer. Output data/valid come straight from
//           registers; in_ready_o is registered and is high while at most one
//           entry is occupied, so a source sampling it late can still land one
//           more beat without overflow.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           in_data_i/valid_i   upstream beat
//           in_ready_o          registered space-available
//           out_data_o/valid_o  head entry
//           out_ready_i         downstream ready
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_skid_buf #(
  parameter int Width = 33
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [Width-1:0] in_data_i,
  input  wire logic             in_valid_i,
  output logic                  in_ready_o,
  output logic [Width-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  wire logic             out_ready_i
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             push;
  logic             pop;

  assign push = in_valid_i && ready_q;
  assign pop  = valid_q && out_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data_i;
        else                 tail_d = in_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the queue shifts by one when two are held.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_data_i;
        end else begin
          head_d = in_data_i;
        end
      end
      default: begin
      end
    endcase
    ready_d = (count_d != 2'd2);
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = head_q;
  assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/axis_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : axis_fifo_wr_arbiter
// Purpose : Packet-level round-robin arbiter sharing one AXI-stream FIFO
//           write port between NumSrc sources. A grant is held until the
//           granted source's last beat is accepted, so packets are never
//           interleaved. The merged stream leaves through a 2-entry skid
//           buffer, making writeData/Valid/Last registered.
// Ports   : clk, rst_n     clock, asynchronous active-low reset
//           arbEnable_i    allows new grants (in-flight packet always finishes)
//           bus            stream bundle (master modport)
//           grantIdx_o     current / last granted source
//           busy_o         high while a packet is being transferred
//           pktCount_o     packets fully accepted into the skid buffer (wraps)
//           beatCount_o    beats accepted in the current packet
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axis_fifo_wr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int DataWidth = 32,
  parameter  int NumSrc    = 2,
  parameter  int CntWidth  = 16,
  localparam int GrantW    = grant_w(NumSrc)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              arbEnable_i,
  axis_fifo_wr_arbiter_if.master bus,
  output logic [GrantW-1:0]      grantIdx_o,
  output logic                   busy_o,
  output logic [CntWidth-1:0]    pktCount_o,
  output logic [CntWidth-1:0]    beatCount_o
);

  arb_state_e          state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [GrantW-1:0]   last_grant_q, last_grant_d;
  logic [CntWidth-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;

  logic [NumSrc-1:0]    src_ready;
  logic [MaxSrc-1:0]    valid_ext;
  logic [DataWidth-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 skid_in_valid;
  logic                 skid_ready;
  logic                 beat_accept;
  logic [DataWidth:0]   skid_out;

  // Granted source's stream; only meaningful while BUSY.
  assign sel_data      = bus.srcData[grant_q];
  assign sel_valid     = bus.srcValid[grant_q];
  assign sel_last      = bus.srcLast[grant_q];
  assign skid_in_valid = (state_q == BUSY) && sel_valid;
  assign beat_accept   = skid_in_valid && skid_ready;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NumSrc-1:0]  = bus.srcValid;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    src_ready    = '0;
    case (state_q)
      IDLE: begin
        // Arbitration bubble: the winner is registered here and served from
        // the next cycle on.
        if (arbEnable_i && (|bus.srcValid)) begin
          grant_d = GrantW'(rr_pick(valid_ext, int'(last_grant_q), NumSrc));
          state_d = BUSY;
        end
      end
      BUSY: begin
        src_ready[grant_q] = skid_ready;
        if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + CntWidth'(1);
          if (sel_last) begin
            pkt_cnt_d    = pkt_cnt_q + CntWidth'(1);
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      // Start "after" the highest index so source 0 wins the first round.
      last_grant_q <= GrantW'(NumSrc - 1);
      pkt_cnt_q    <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  axis_skid_buf #(
    .Width (DataWidth + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_i   ({sel_last, sel_data}),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_ready),
    .out_data_o  (skid_out),
    .out_valid_o (bus.writeDataValid),
    .out_ready_i (bus.writeDataReady)
  );

  assign bus.srcReady      = src_ready;
  assign bus.writeData     = skid_out[DataWidth-1:0];
  assign bus.writeDataLast = skid_out[DataWidth];

  assign grantIdx_o  = grant_q;
  assign busy_o      = (state_q == BUSY);
  assign pktCount_o  = pkt_cnt_q;
  assign beatCount_o = beat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_axis_fifo_wr_arbiter
// Purpose : Directed self-checking bench for axis_fifo_wr_arbiter with two
//           16-beat counting sources (data = src*256 + beat, last on beat 15).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axis_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NS = 2;
  localparam int CW = 16;
  localparam int GW = 1;

  logic          clk;
  logic          rst_n;
  logic          arbEnable;
  logic [GW-1:0] grantIdx;
  logic          busy;
  logic [CW-1:0] pktCount;
  logic [CW-1:0] beatCount;

  axis_fifo_wr_arbiter_if #(.DataWidth(DW), .NumSrc(NS)) bus ();

  axis_fifo_wr_arbiter #(
    .DataWidth (DW),
    .NumSrc    (NS),
    .CntWidth  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arbEnable_i (arbEnable),
    .bus         (bus),
    .grantIdx_o  (grantIdx),
    .busy_o      (busy),
    .pktCount_o  (pktCount),
    .beatCount_o (beatCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int cnt [NS];
  logic [NS-1:0] en;
  logic [NS-1:0] fire;

  logic [31:0]   got_q    [$];
  int            got_cyc  [$];
  int            got_pkt  [$];
  int            got_grant[$];

  logic [31:0]   smp_wdata;
  logic          smp_wvalid;
  logic [NS-1:0] smp_fire;
  logic [NS-1:0] smp_rdy;
  int            rdy0_hi;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int s, input int b);
    logic [31:0] d;
    d = 32'(s * 256 + b);
    return {(b == 15), d[30:0]};
  endfunction

  task automatic drive_src();
    for (int s = 0; s < NS; s++) begin
      bus.srcData[s]  = 32'(s * 256 + cnt[s]);
      bus.srcLast[s]  = (cnt[s] == 15);
      bus.srcValid[s] = en[s];
    end
  endtask

  // One clock: apply stimulus, sample at negedge, advance source counters.
  task automatic cycle();
    drive_src();
    @(negedge clk);
    fire       = bus.srcValid & bus.srcReady;
    smp_fire   = fire;
    smp_rdy    = bus.srcReady;
    smp_wdata  = bus.writeData;
    smp_wvalid = bus.writeDataValid;
    if (bus.srcReady[0]) rdy0_hi++;
    if (bus.writeDataValid && bus.writeDataReady) begin
      got_q.push_back({bus.writeDataLast, bus.writeData[30:0]});
      got_cyc.push_back(cyc);
      got_pkt.push_back(int'(pktCount));
      got_grant.push_back(int'(grantIdx));
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (fire[s]) cnt[s] = (cnt[s] == 15) ? 0 : cnt[s] + 1;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    got_pkt.delete();
    got_grant.delete();
    rdy0_hi = 0;
    for (int s = 0; s < NS; s++) cnt[s] = 0;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    en                 = '0;
    arbEnable          = 1'b1;
    bus.writeDataReady = 1'b1;
    clear_obs();
    drive_src();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run_beats(input int n, input int limit);
    int k;
    k = 0;
    while (got_q.size() < n && k < limit) begin
      cycle();
      k++;
    end
  endtask

  task automatic check_pkt(input string tag, input int base, input int s);
    for (int b = 0; b < 16; b++) begin
      if (base + b < got_q.size()) check_val(tag, got_q[base + b], exp_word(s, b));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k, rel, changed, stall_fires, gap_bad, gap_n, drop_left;
    logic [31:0] frozen;
    logic rdy20, dropped, busy_pre;
    logic [CW-1:0] beat20, pkt_pre;

    // Reset state
    do_reset();
    check_val("rst_wvalid", bus.writeDataValid, 0);
    check_val("rst_wdata", bus.writeData, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_grant", grantIdx, 0);
    check_val("rst_pkt", pktCount, 0);
    check_val("rst_srcrdy", bus.srcReady, 0);

    // T1: both sources valid, FIFO always ready -> alternating packets
    do_reset();
    en = 2'b11;
    run_beats(64, 400);
    check_val("t1_nbeats", got_q.size(), 64);
    check_pkt("t1_p0", 0, 0);
    check_pkt("t1_p1", 16, 1);
    check_pkt("t1_p2", 32, 0);
    check_pkt("t1_p3", 48, 1);
    if (got_q.size() >= 64) begin
      check_val("t1_burst", got_cyc[15] - got_cyc[0], 15);
      check_val("t1_bubble", got_cyc[16] - got_cyc[15], 2);
      check_val("t1_pktcnt", got_pkt[63], 4);
      check_val("t1_grant0", got_grant[15], 0);
      check_val("t1_grant1", got_grant[31], 1);
    end

    // T2: only source 1 valid
    do_reset();
    repeat (3) cycle();
    k0 = cyc;
    en = 2'b10;
    run_beats(32, 200);
    check_val("t2_nbeats", got_q.size(), 32);
    check_pkt("t2_p0", 0, 1);
    check_pkt("t2_p1", 16, 1);
    if (got_q.size() >= 32) begin
      check_val("t2_latency", got_cyc[0] - k0, 2);
      check_val("t2_grant_a", got_grant[15], 1);
      check_val("t2_grant_b", got_grant[31], 1);
    end
    check_val("t2_src0_rdy", rdy0_hi, 0);

    // T3: FIFO back-pressure for cycles 5..20 of a src0 packet
    do_reset();
    en = 2'b01;
    k0 = cyc; k = 0; changed = 0; stall_fires = 0; frozen = '0; rdy20 = 1'b1; beat20 = '0;
    while (got_q.size() < 16 && k < 200) begin
      rel = cyc - k0;
      bus.writeDataReady = !(rel >= 5 && rel <= 20);
      cycle();
      k++;
      if (rel == 5) frozen = smp_wdata;
      if (rel >= 5 && rel <= 20) begin
        if (smp_wdata !== frozen || !smp_wvalid) changed++;
        stall_fires += int'(smp_fire[0]);
      end
      if (rel == 20) begin
        rdy20  = smp_rdy[0];
        beat20 = beatCount;
      end
    end
    bus.writeDataReady = 1'b1;
    check_val("t3_nbeats", got_q.size(), 16);
    check_pkt("t3_seq", 0, 0);
    check_val("t3_frozen", changed, 0);
    check_val("t3_fires_le2", (stall_fires <= 2), 1);
    check_val("t3_rdy_drop", rdy20, 0);
    check_val("t3_beatcnt", beat20, 5);

    // T4: arbEnable dropped at beat 7 of a src0 packet
    do_reset();
    en = 2'b11;
    dropped = 1'b0; k = 0;
    while (got_q.size() < 16 && k < 200) begin
      if (!dropped && cnt[0] == 7) begin
        arbEnable = 1'b0;
        dropped   = 1'b1;
      end
      cycle();
      k++;
    end
    repeat (10) cycle();
    check_val("t4_nbeats", got_q.size(), 16);
    check_pkt("t4_p0", 0, 0);
    check_val("t4_busy_off", busy, 0);
    check_val("t4_grant_hold", grantIdx, 0);
    arbEnable = 1'b1;
    run_beats(32, 100);
    check_val("t4_nbeats2", got_q.size(), 32);
    check_pkt("t4_p1", 16, 1);

    // T5: src0 drops valid for 3 cycles at beat 4 while src1 waits
    do_reset();
    en = 2'b11;
    dropped = 1'b0; drop_left = 0; gap_bad = 0; gap_n = 0; k = 0;
    while (got_q.size() < 32 && k < 300) begin
      if (!dropped && cnt[0] == 4) begin
        dropped   = 1'b1;
        drop_left = 3;
      end
      if (drop_left > 0) begin
        en[0] = 1'b0;
        drop_left--;
        cycle();
        gap_n++;
        if (grantIdx !== 1'b0 || busy !== 1'b1) gap_bad++;
      end else begin
        en[0] = 1'b1;
        cycle();
      end
      k++;
    end
    check_val("t5_nbeats", got_q.size(), 32);
    check_pkt("t5_p0", 0, 0);
    check_pkt("t5_p1", 16, 1);
    check_val("t5_gap_len", gap_n, 3);
    check_val("t5_gap_lock", gap_bad, 0);

    // T6: reset asserted at beat 9 of a src1 packet
    do_reset();
    en = 2'b11;
    k = 0;
    while (cnt[1] != 9 && k < 200) begin
      cycle();
      k++;
    end
    check_val("t6_reached", cnt[1], 9);
    pkt_pre  = pktCount;
    busy_pre = busy;
    check_val("t6_pre_pkt", pkt_pre, 1);
    check_val("t6_pre_busy", busy_pre, 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_wvalid", bus.writeDataValid, 0);
    check_val("t6_wdata", bus.writeData, 0);
    check_val("t6_wlast", bus.writeDataLast, 0);
    check_val("t6_srcrdy", bus.srcReady, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_grant", grantIdx, 0);
    check_val("t6_pkt", pktCount, 0);
    check_val("t6_beat", beatCount, 0);
    clear_obs();
    drive_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    run_beats(16, 100);
    check_val("t6_nbeats", got_q.size(), 16);
    check_pkt("t6_first_src0", 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_fifo_wr_arbiter.md
Name: axis_fifo_wr_arbiter

Overview:
- Packet-level round-robin arbiter sharing the fifo_2048 AXI-stream write port between NumSrc stream sources (e.g. several counter_up generators).
- Grants one source at a time and holds the grant until that source's last beat is accepted, so packets are never interleaved in the FIFO.
- Output passes through a 2-entry skid buffer, so writeData/writeDataValid/writeDataLast are registered.
- Provides an enable gate and packet/beat status counters for the controlling testbench or host.

Parameters:
- DataWidth, 32, width of stream data.
- NumSrc, 2, number of requesting sources (2..8).
- CntWidth, 16, width of status counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- arbEnable  in  1  when 1, new grants allowed; when 0, the in-flight packet completes and no new grant is issued.
- srcData  in  NumSrc x DataWidth  per-source data.
- srcValid  in  NumSrc  per-source valid.
- srcLast  in  NumSrc  per-source last.
- srcReady  out  NumSrc  per-source ready.
- writeData  out  DataWidth  to FIFO writeData.
- writeDataValid  out  1  to FIFO.
- writeDataLast  out  1  to FIFO.
- writeDataReady  in  1  from FIFO.
- grantIdx  out  $clog2(NumSrc)  currently/last granted source.
- busy  out  1  1 while in BUSY state.
- pktCount  out  CntWidth  packets fully accepted into the skid buffer; wraps.
- beatCount  out  CntWidth  beats accepted in the current packet; cleared on IDLE entry.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs 0, state IDLE, skid buffer empty.
  - lastGrant internal = NumSrc-1, so source 0 wins first.
- State IDLE:
  - If arbEnable && |srcValid, select the first valid index searching lastGrant+1, lastGrant+2, ... modulo NumSrc.
  - Register it into grantIdx and go to BUSY next cycle. This costs one arbitration bubble cycle.
  - All srcReady are 0 in IDLE.
- State BUSY:
  - srcReady[grantIdx] = skidReady; all other srcReady are 0.
  - A beat is accepted when srcValid[g] && srcReady[g]. It is pushed into the skid buffer and beatCount increments.
  - If the accepted beat has srcLast[g]=1: pktCount++, lastGrant<=grantIdx, state->IDLE next cycle.
- Grant lock: grant never changes mid-packet, whatever other sources or arbEnable do.
- Deassertion of srcValid[g] mid-packet: stay BUSY and wait.
- arbEnable low while BUSY: no effect until the last beat; then remain in IDLE.
- Latency: srcValid rises at cycle 0 in IDLE -> grant at cycle 1 -> first beat accepted at cycle 1 (if skid empty) -> writeDataValid at cycle 2.
- Throughput: 1 beat/cycle within a packet; 1 idle input cycle between packets.
- Skid buffer:
  - 2 entries. skidReady is registered and equals "not more than one entry occupied".
  - Output holds data/last stable while writeDataValid && !writeDataReady (AXI rule; valid never drops without a handshake).
- Simultaneous events: push and pop in the same cycle keep occupancy unchanged.
- Empty packet is impossible: a single beat with last=1 is a 1-beat packet.
- Counter wrap: pktCount and beatCount wrap modulo 2^CntWidth with no flag.
- Reset mid-packet: immediate return to reset values. The partial packet is dropped from the skid buffer; the FIFO may hold a truncated packet, and the system reset is responsible for clearing it.

Decomposition:
- Package axis_arb_pkg: typedef arb_state_e {IDLE, BUSY}; localparam GrantW = $clog2(NumSrc) helper; round-robin select function rr_pick(valid, lastGrant).
- Sub-module axis_skid_buf (DataWidth+1 bits, 2 entries, same clk/reset).
- Arbiter FSM and counters live in the top module.

Test Plan:
- Two counter_up sources with count_up_to=16, both valid from cycle 0, FIFO always ready -> FIFO receives src0 beats 0..15 (last on beat 15), then src1 0..15, alternating; pktCount=4 after 4 packets; 1 bubble between packets.
- Only src1 valid -> grantIdx=1 every packet; src0 srcReady stays 0; first writeDataValid exactly 2 cycles after srcValid[1] rises.
- writeDataReady=0 for cycles 5..20 mid-packet -> writeData frozen; srcReady drops within 2 accepted beats; no beat lost or duplicated (check the 0..15 sequence).
- arbEnable dropped at beat 7 of a src0 packet -> packet completes through beat 15 with last; busy=0 after; no new grant until arbEnable=1, then src1 granted.
- src0 drops valid for 3 cycles at beat 4 while src1 is valid -> grant stays 0; src1 not served until src0's last is accepted.
- Assert reset low at beat 9 of a packet -> within the same cycle all outputs are 0 and pktCount=0; after release, src0 is granted first.
